// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between requesters A and B; IDLE->EXEC->RESP per op.
// Latency: request handshake at edge N, response valid after edge N+1; response held until owner rsp_ready.
module alu_arbiter #(
   parameter int DW = 32,
   parameter int IW = 37
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req_valid,
   output logic          a_req_ready,
   input  logic [DW-1:0] a_rs1,
   input  logic [DW-1:0] a_rs2,
   input  logic [DW-1:0] a_imm,
   input  logic [IW-1:0] a_instr,
   output logic          a_rsp_valid,
   input  logic          a_rsp_ready,
   output logic [DW-1:0] a_rsp_data,
   output logic          a_rsp_err,
   input  logic          b_req_valid,
   output logic          b_req_ready,
   input  logic [DW-1:0] b_rs1,
   input  logic [DW-1:0] b_rs2,
   input  logic [DW-1:0] b_imm,
   input  logic [IW-1:0] b_instr,
   output logic          b_rsp_valid,
   input  logic          b_rsp_ready,
   output logic [DW-1:0] b_rsp_data,
   output logic          b_rsp_err,
   output logic [DW-1:0] alu_rs1,
   output logic [DW-1:0] alu_rs2,
   output logic [DW-1:0] alu_imm,
   output logic [IW-1:0] alu_instr,
   input  logic [DW-1:0] alu_result,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [IW-1:0] ONE = {{(IW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic          rr_ptr_q, rr_ptr_d;   // 0 = A has priority, 1 = B
   logic          owner_q, owner_d;     // 0 = A, 1 = B
   logic          err_q, err_d;
   logic [DW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, result_q, result_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          grant_a, grant_b;

   function automatic logic is_onehot(input logic [IW-1:0] v);
      return (v != '0) && ((v & (v - ONE)) == '0);
   endfunction

   always_comb begin
      grant_a = (state_q == IDLE) && a_req_valid && (!b_req_valid || !rr_ptr_q);
      grant_b = (state_q == IDLE) && b_req_valid && (!a_req_valid ||  rr_ptr_q);

      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      err_d    = err_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;
      instr_d  = instr_q;
      result_d = result_q;

      unique case (state_q)
         IDLE: begin
            if (grant_a) begin
               rs1_d    = a_rs1;
               rs2_d    = a_rs2;
               imm_d    = a_imm;
               instr_d  = a_instr;
               err_d    = !is_onehot(a_instr);
               owner_d  = 1'b0;
               rr_ptr_d = 1'b1;
               state_d  = EXEC;
            end else if (grant_b) begin
               rs1_d    = b_rs1;
               rs2_d    = b_rs2;
               imm_d    = b_imm;
               instr_d  = b_instr;
               err_d    = !is_onehot(b_instr);
               owner_d  = 1'b1;
               rr_ptr_d = 1'b0;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_result;
            state_d  = RESP;
         end
         RESP: begin
            if (owner_q ? b_rsp_ready : a_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= 1'b0;
         owner_q  <= 1'b0;
         err_q    <= 1'b0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         instr_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         err_q    <= err_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         instr_q  <= instr_d;
         result_q <= result_d;
      end
   end

   assign a_req_ready = grant_a;
   assign b_req_ready = grant_b;

   // Opcode is gated outside EXEC so the ALU idles at zero.
   assign alu_rs1   = rs1_q;
   assign alu_rs2   = rs2_q;
   assign alu_imm   = imm_q;
   assign alu_instr = (state_q == EXEC) ? instr_q : '0;

   assign a_rsp_valid = (state_q == RESP) && !owner_q;
   assign b_rsp_valid = (state_q == RESP) &&  owner_q;
   assign a_rsp_data  = a_rsp_valid ? result_q : '0;
   assign b_rsp_data  = b_rsp_valid ? result_q : '0;
   assign a_rsp_err   = a_rsp_valid && err_q;
   assign b_rsp_err   = b_rsp_valid && err_q;

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU; checks on the falling edge.
module tb_alu_arbiter;
   localparam int DW = 32;
   localparam int IW = 37;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [DW-1:0] a_rs1, a_rs2, a_imm, a_rsp_data;
   logic [IW-1:0] a_instr;
   logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [DW-1:0] b_rs1, b_rs2, b_imm, b_rsp_data;
   logic [IW-1:0] b_instr;
   logic [DW-1:0] alu_rs1, alu_rs2, alu_imm, alu_result;
   logic [IW-1:0] alu_instr;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DW(DW), .IW(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
      .a_rs1(a_rs1), .a_rs2(a_rs2), .a_imm(a_imm), .a_instr(a_instr),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
      .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
      .b_rs1(b_rs1), .b_rs2(b_rs2), .b_imm(b_imm), .b_instr(b_instr),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
      .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
      .alu_instr(alu_instr), .alu_result(alu_result), .busy(busy)
   );

   // Reference ALU: exact one-hot codes only, anything else yields zero.
   always_comb begin
      case (alu_instr)
         37'h1:   alu_result = alu_rs1 + alu_rs2;
         37'h2:   alu_result = alu_rs1 - alu_rs2;
         37'h4:   alu_result = alu_rs1 ^ alu_rs2;
         37'h8:   alu_result = alu_rs1 + alu_imm;
         default: alu_result = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_a(input logic v, input logic [IW-1:0] ins, input logic [DW-1:0] r1,
                        input logic [DW-1:0] r2);
      a_req_valid = v; a_instr = ins; a_rs1 = r1; a_rs2 = r2;
   endtask

   task automatic set_b(input logic v, input logic [IW-1:0] ins, input logic [DW-1:0] r1,
                        input logic [DW-1:0] r2, input logic [DW-1:0] im);
      b_req_valid = v; b_instr = ins; b_rs1 = r1; b_rs2 = r2; b_imm = im;
   endtask

   initial begin
      rst_n = 1'b0;
      set_a(0, '0, '0, '0); a_imm = '0; a_rsp_ready = 1'b0;
      set_b(0, '0, '0, '0, '0); b_rsp_ready = 1'b0;
      cyc(); cyc();
      chk("rst_busy", busy, 0);
      chk("rst_a_rsp_valid", a_rsp_valid, 0);
      chk("rst_b_rsp_valid", b_rsp_valid, 0);
      chk("rst_alu_instr", alu_instr, 0);
      chk("rst_alu_rs1", alu_rs1, 0);
      rst_n = 1'b1;

      // 1: A only, add 5+7
      cyc(); set_a(1, 37'h1, 5, 7); #1;
      chk("t1_a_ready", a_req_ready, 1);
      chk("t1_b_ready", b_req_ready, 0);
      cyc(); set_a(0, '0, '0, '0); #1;
      chk("t1_exec_busy", busy, 1);
      chk("t1_exec_instr", alu_instr, 37'h1);
      chk("t1_exec_valid", a_rsp_valid, 0);
      cyc();
      chk("t1_rsp_valid", a_rsp_valid, 1);
      chk("t1_rsp_data", a_rsp_data, 12);
      chk("t1_rsp_err", a_rsp_err, 0);
      chk("t1_rsp_instr_idle", alu_instr, 0);
      a_rsp_ready = 1'b1;
      cyc(); a_rsp_ready = 1'b0; #1;
      chk("t1_back_idle", busy, 0);

      // 2: A and B together; rr pointer now points at B after A's op
      set_a(1, 37'h2, 9, 4); set_b(1, 37'h4, 32'hF0, 32'h0F, 0); #1;
      chk("t2_b_first_rr", b_req_ready, 1);
      chk("t2_a_blocked", a_req_ready, 0);
      cyc(); set_b(0, '0, '0, '0, '0); #1;
      chk("t2_exec_no_ready", a_req_ready, 0);
      cyc();
      chk("t2_b_valid", b_rsp_valid, 1);
      chk("t2_b_data", b_rsp_data, 32'hFF);
      chk("t2_a_not_valid", a_rsp_valid, 0);
      b_rsp_ready = 1'b1;
      cyc(); b_rsp_ready = 1'b0;
      set_b(1, 37'h8, 3, 0, 4); #1;
      chk("t2_a_next", a_req_ready, 1);
      chk("t2_b_wait", b_req_ready, 0);
      cyc(); set_a(0, '0, '0, '0);
      cyc();
      chk("t2_a_data", a_rsp_data, 5);

      // 3: backpressure on A with B waiting
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t3_hold_valid", a_rsp_valid, 1);
         chk("t3_hold_data", a_rsp_data, 5);
         chk("t3_no_b_ready", b_req_ready, 0);
      end
      a_rsp_ready = 1'b1;
      cyc(); a_rsp_ready = 1'b0; #1;
      chk("t3_b_granted", b_req_ready, 1);
      cyc(); set_b(0, '0, '0, '0, '0);
      cyc();
      chk("t3_b_imm_data", b_rsp_data, 7);
      chk("t3_b_err", b_rsp_err, 0);
      b_rsp_ready = 1'b1;
      cyc(); b_rsp_ready = 1'b0;

      // 4: malformed opcodes still issue, flag error
      set_a(1, 37'h3, 5, 7); #1;
      chk("t4_mh_ready", a_req_ready, 1);
      cyc(); set_a(0, '0, '0, '0); #1;
      chk("t4_mh_alu_instr", alu_instr, 37'h3);
      cyc();
      chk("t4_mh_err", a_rsp_err, 1);
      chk("t4_mh_data", a_rsp_data, 0);
      a_rsp_ready = 1'b1;
      cyc(); a_rsp_ready = 1'b0;
      set_a(1, 37'h0, 5, 7);
      cyc(); set_a(0, '0, '0, '0);
      cyc();
      chk("t4_zero_valid", a_rsp_valid, 1);
      chk("t4_zero_err", a_rsp_err, 1);
      chk("t4_zero_data", a_rsp_data, 0);
      a_rsp_ready = 1'b1;
      cyc(); a_rsp_ready = 1'b0;

      // 5: reset during EXEC, then during RESP
      set_a(1, 37'h1, 1, 2);
      cyc(); set_a(0, '0, '0, '0); rst_n = 1'b0; #1;
      chk("t5_in_exec", busy, 1);
      cyc(); rst_n = 1'b1;
      chk("t5e_busy", busy, 0);
      chk("t5e_alu_instr", alu_instr, 0);
      chk("t5e_alu_rs1", alu_rs1, 0);
      cyc();
      chk("t5e_no_rsp", a_rsp_valid, 0);
      set_a(1, 37'h1, 1, 2);
      cyc(); set_a(0, '0, '0, '0);
      cyc();
      chk("t5r_in_resp", a_rsp_valid, 1);
      rst_n = 1'b0;
      cyc(); rst_n = 1'b1;
      chk("t5r_valid", a_rsp_valid, 0);
      chk("t5r_data", a_rsp_data, 0);
      chk("t5r_busy", busy, 0);
      set_b(1, 37'h1, 3, 4, 0); #1;
      chk("t5_b_ready", b_req_ready, 1);
      cyc(); set_b(0, '0, '0, '0, '0);
      begin
         int n = 0;
         while (!b_rsp_valid && n < 10) begin cyc(); n++; end
         chk("t5_b_latency", n, 1);
      end
      chk("t5_b_data", b_rsp_data, 7);
      chk("t5_b_err", b_rsp_err, 0);
      chk("t5_a_quiet", a_rsp_valid, 0);
      b_rsp_ready = 1'b1;
      cyc(); b_rsp_ready = 1'b0;
      // pointer after reset was A, B served last -> A priority
      set_a(1, 37'h1, 0, 0); set_b(1, 37'h1, 0, 0, 0); #1;
      chk("t5_rr_a", a_req_ready, 1);
      chk("t5_rr_b", b_req_ready, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
